// File: rtl/rx_payload_enq_ctrl.sv
// rtl/rx_payload_enq_ctrl.sv - per-packet query/enqueue/result sequencer for the RX payload queue
module rx_payload_enq_ctrl #(
  parameter int FLOW_ID_W = 8,
  parameter int Q_SIZE_W  = 3,
  parameter int ENTRY_W   = 64,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pkt_val,
  input  logic [FLOW_ID_W-1:0] pkt_flowid,
  input  logic [ENTRY_W-1:0]   pkt_data,
  output logic                 pkt_rdy,
  output logic                 q_full_req_val,
  output logic [FLOW_ID_W-1:0] q_full_req_flowid,
  input  logic                 q_full_req_rdy,
  input  logic                 q_full_resp_val,
  input  logic [Q_SIZE_W:0]    q_full_resp_tail_index,
  input  logic [Q_SIZE_W:0]    q_full_resp_head_index,
  output logic                 q_full_resp_rdy,
  output logic                 enqueue_pkt_req_val,
  output logic [FLOW_ID_W-1:0] enqueue_pkt_req_flowid,
  output logic [Q_SIZE_W:0]    enqueue_pkt_req_index,
  output logic [ENTRY_W-1:0]   enqueue_pkt_req_data,
  input  logic                 enqueue_pkt_req_rdy,
  output logic                 pkt_result_val,
  output logic [FLOW_ID_W-1:0] pkt_result_flowid,
  output logic                 pkt_result_dropped,
  input  logic                 pkt_result_rdy,
  output logic [CNT_W-1:0]     enq_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_ENQ,
    S_RESULT
  } state_t;

  state_t state, state_nxt;

  logic [FLOW_ID_W-1:0] flowid_r;
  logic [ENTRY_W-1:0]   data_r;
  logic [Q_SIZE_W:0]    tail_r;
  logic [Q_SIZE_W:0]    occ;
  logic                 dropped_r;
  logic [CNT_W-1:0]     enq_cnt_r;
  logic [CNT_W-1:0]     drop_cnt_r;
  logic                 pkt_xfer, resp_xfer, enq_xfer;
  logic                 q_full;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Modular occupancy: MSB set means occ >= depth (full, or a corrupt pointer pair)
  assign occ    = q_full_resp_tail_index - q_full_resp_head_index;
  assign q_full = occ[Q_SIZE_W];

  assign pkt_xfer  = pkt_val & pkt_rdy;
  assign resp_xfer = q_full_resp_val & q_full_resp_rdy;
  assign enq_xfer  = enqueue_pkt_req_val & enqueue_pkt_req_rdy;

  assign q_full_req_flowid      = flowid_r;
  assign enqueue_pkt_req_flowid = flowid_r;
  assign enqueue_pkt_req_index  = tail_r;
  assign enqueue_pkt_req_data   = data_r;
  assign pkt_result_flowid      = flowid_r;
  assign pkt_result_dropped     = dropped_r;
  assign enq_cnt                = enq_cnt_r;
  assign drop_cnt               = drop_cnt_r;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Handshake outputs are masked during reset so nothing transfers on that edge
  always_comb begin
    state_nxt           = state;
    pkt_rdy             = 1'b0;
    q_full_req_val      = 1'b0;
    q_full_resp_rdy     = 1'b0;
    enqueue_pkt_req_val = 1'b0;
    pkt_result_val      = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          pkt_rdy = 1'b1;
          if (pkt_val) state_nxt = S_QUERY;
        end
        S_QUERY: begin
          q_full_req_val = 1'b1;
          if (q_full_req_rdy) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          q_full_resp_rdy = 1'b1;
          if (q_full_resp_val) state_nxt = q_full ? S_RESULT : S_ENQ;
        end
        S_ENQ: begin
          enqueue_pkt_req_val = 1'b1;
          if (enqueue_pkt_req_rdy) state_nxt = S_RESULT;
        end
        S_RESULT: begin
          pkt_result_val = 1'b1;
          if (pkt_result_rdy) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flowid_r   <= '0;
      data_r     <= '0;
      tail_r     <= '0;
      dropped_r  <= 1'b0;
      enq_cnt_r  <= '0;
      drop_cnt_r <= '0;
    end else begin
      if (pkt_xfer) begin
        flowid_r <= pkt_flowid;
        data_r   <= pkt_data;
      end
      if (resp_xfer) begin
        tail_r <= q_full_resp_tail_index;
        if (q_full) begin
          dropped_r <= 1'b1;
          if (drop_cnt_r != '1) drop_cnt_r <= drop_cnt_r + CNT_ONE;
        end
      end
      if (enq_xfer) begin
        dropped_r <= 1'b0;
        if (enq_cnt_r != '1) enq_cnt_r <= enq_cnt_r + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_rx_payload_enq_ctrl.sv
// tb/tb_rx_payload_enq_ctrl.sv - randomized self-checking bench for rx_payload_enq_ctrl
module tb_rx_payload_enq_ctrl;
  localparam int FLOW_ID_W = 8;
  localparam int Q_SIZE_W  = 3;
  localparam int ENTRY_W   = 64;
  localparam int CNT_W     = 2;
  localparam int DEPTH     = 1 << Q_SIZE_W;
  localparam int IDX_MOD   = 1 << (Q_SIZE_W + 1);
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 pkt_val = 1'b0;
  logic [FLOW_ID_W-1:0] pkt_flowid = '0;
  logic [ENTRY_W-1:0]   pkt_data = '0;
  logic                 pkt_rdy;
  logic                 q_full_req_val;
  logic [FLOW_ID_W-1:0] q_full_req_flowid;
  logic                 q_full_req_rdy = 1'b0;
  logic                 q_full_resp_val = 1'b0;
  logic [Q_SIZE_W:0]    q_full_resp_tail_index = '0;
  logic [Q_SIZE_W:0]    q_full_resp_head_index = '0;
  logic                 q_full_resp_rdy;
  logic                 enqueue_pkt_req_val;
  logic [FLOW_ID_W-1:0] enqueue_pkt_req_flowid;
  logic [Q_SIZE_W:0]    enqueue_pkt_req_index;
  logic [ENTRY_W-1:0]   enqueue_pkt_req_data;
  logic                 enqueue_pkt_req_rdy = 1'b0;
  logic                 pkt_result_val;
  logic [FLOW_ID_W-1:0] pkt_result_flowid;
  logic                 pkt_result_dropped;
  logic                 pkt_result_rdy = 1'b0;
  logic [CNT_W-1:0]     enq_cnt;
  logic [CNT_W-1:0]     drop_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_enq  = 0;
  int exp_drop = 0;

  rx_payload_enq_ctrl #(
    .FLOW_ID_W(FLOW_ID_W), .Q_SIZE_W(Q_SIZE_W), .ENTRY_W(ENTRY_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .pkt_val(pkt_val), .pkt_flowid(pkt_flowid), .pkt_data(pkt_data), .pkt_rdy(pkt_rdy),
    .q_full_req_val(q_full_req_val), .q_full_req_flowid(q_full_req_flowid),
    .q_full_req_rdy(q_full_req_rdy),
    .q_full_resp_val(q_full_resp_val), .q_full_resp_tail_index(q_full_resp_tail_index),
    .q_full_resp_head_index(q_full_resp_head_index), .q_full_resp_rdy(q_full_resp_rdy),
    .enqueue_pkt_req_val(enqueue_pkt_req_val), .enqueue_pkt_req_flowid(enqueue_pkt_req_flowid),
    .enqueue_pkt_req_index(enqueue_pkt_req_index), .enqueue_pkt_req_data(enqueue_pkt_req_data),
    .enqueue_pkt_req_rdy(enqueue_pkt_req_rdy),
    .pkt_result_val(pkt_result_val), .pkt_result_flowid(pkt_result_flowid),
    .pkt_result_dropped(pkt_result_dropped), .pkt_result_rdy(pkt_result_rdy),
    .enq_cnt(enq_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end, actual timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    check_eq("pkt_rdy_in_reset", pkt_rdy, 0);
    rst = 1'b0;
    exp_enq  = 0;
    exp_drop = 0;
    #1;
    check_eq("rst_pkt_rdy", pkt_rdy, 1);
    check_eq("rst_vals", {q_full_req_val, enqueue_pkt_req_val, pkt_result_val, q_full_resp_rdy}, 0);
    check_eq("rst_dropped", pkt_result_dropped, 0);
    check_eq("rst_enq_cnt", enq_cnt, 0);
    check_eq("rst_drop_cnt", drop_cnt, 0);
  endtask

  // One packet through every stage; each stage is stalled for the given number of cycles.
  // With abort set, returns while the enqueue request is still pending.
  task automatic run_pkt(input logic [FLOW_ID_W-1:0] f, input logic [ENTRY_W-1:0] d,
                         input int tl, input int hd, input int qd, input int rd,
                         input int ed, input int od, input bit abort);
    int  occ;
    bit  drop;
    occ  = (tl - hd + IDX_MOD) % IDX_MOD;
    drop = (occ >= DEPTH);

    check_eq("pkt_rdy_idle", pkt_rdy, 1);
    pkt_val = 1'b1; pkt_flowid = f; pkt_data = d;
    tick();
    pkt_val = 1'b0; pkt_flowid = FLOW_ID_W'($urandom); pkt_data = {$urandom, $urandom};

    repeat (qd) begin
      q_full_resp_val = 1'b1;
      q_full_resp_tail_index = (Q_SIZE_W+1)'($urandom);
      #1;
      check_eq("query_hold_val", q_full_req_val, 1);
      check_eq("query_hold_flowid", q_full_req_flowid, f);
      check_eq("query_pkt_rdy", pkt_rdy, 0);
      check_eq("stray_resp_rdy", q_full_resp_rdy, 0);
      tick();
      q_full_resp_val = 1'b0;
    end
    q_full_req_rdy = 1'b1;
    check_eq("query_val", q_full_req_val, 1);
    check_eq("query_flowid", q_full_req_flowid, f);
    tick();
    q_full_req_rdy = 1'b0;

    repeat (rd) begin
      check_eq("wait_resp_rdy", q_full_resp_rdy, 1);
      check_eq("wait_no_query", q_full_req_val, 0);
      tick();
    end
    q_full_resp_val = 1'b1;
    q_full_resp_tail_index = (Q_SIZE_W+1)'(tl);
    q_full_resp_head_index = (Q_SIZE_W+1)'(hd);
    check_eq("resp_rdy", q_full_resp_rdy, 1);
    tick();
    q_full_resp_val = 1'b0;

    if (!drop) begin
      repeat (ed) begin
        check_eq("enq_hold_val", enqueue_pkt_req_val, 1);
        check_eq("enq_hold_index", enqueue_pkt_req_index, tl);
        check_eq("enq_hold_data", enqueue_pkt_req_data, d);
        check_eq("enq_pkt_rdy", pkt_rdy, 0);
        tick();
      end
      if (abort) return;
      enqueue_pkt_req_rdy = 1'b1;
      check_eq("enq_val", enqueue_pkt_req_val, 1);
      check_eq("enq_flowid", enqueue_pkt_req_flowid, f);
      check_eq("enq_index", enqueue_pkt_req_index, tl);
      check_eq("enq_data", enqueue_pkt_req_data, d);
      tick();
      enqueue_pkt_req_rdy = 1'b0;
      exp_enq = sat_inc(exp_enq);
    end else begin
      exp_drop = sat_inc(exp_drop);
    end

    repeat (od) begin
      check_eq("res_hold_val", pkt_result_val, 1);
      check_eq("res_hold_dropped", pkt_result_dropped, drop);
      check_eq("res_no_enq", enqueue_pkt_req_val, 0);
      tick();
    end
    pkt_result_rdy = 1'b1;
    check_eq("res_val", pkt_result_val, 1);
    check_eq("res_flowid", pkt_result_flowid, f);
    check_eq("res_dropped", pkt_result_dropped, drop);
    check_eq("res_no_enq", enqueue_pkt_req_val, 0);
    tick();
    pkt_result_rdy = 1'b0;

    check_eq("done_res_val", pkt_result_val, 0);
    check_eq("done_pkt_rdy", pkt_rdy, 1);
    check_eq("enq_cnt", enq_cnt, exp_enq);
    check_eq("drop_cnt", drop_cnt, exp_drop);
  endtask

  initial begin
    do_reset();

    run_pkt(8'd7,  64'hDEAD_BEEF_0123_4567, 5,  2,  0, 0, 0, 0, 0);
    run_pkt(8'd3,  64'h1111_2222_3333_4444, 9,  1,  0, 0, 0, 0, 0);
    run_pkt(8'd9,  64'hCAFE_F00D_0000_0001, 0,  15, 0, 0, 0, 0, 0);
    run_pkt(8'd12, 64'h5555_AAAA_5555_AAAA, 10, 1,  0, 0, 0, 0, 0);
    run_pkt(8'hA5, 64'h0F0F_F0F0_1234_5678, 3,  0,  3, 2, 3, 3, 0);

    do_reset();
    for (int i = 0; i < 5; i++)
      run_pkt(FLOW_ID_W'(i + 1), {$urandom, $urandom}, i, i, 0, 0, 0, 0, 0);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      int hd, occ;
      hd  = $urandom_range(0, IDX_MOD - 1);
      occ = $urandom_range(0, IDX_MOD - 1);
      run_pkt(FLOW_ID_W'($urandom), {$urandom, $urandom}, (hd + occ) % IDX_MOD, hd,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 0);
      if (i == 29) do_reset();
    end

    do_reset();
    run_pkt(8'h42, 64'h0123_4567_89AB_CDEF, 6, 4, 0, 0, 0, 0, 0);
    run_pkt(8'h43, 64'hFEDC_BA98_7654_3210, 2, 1, 1, 1, 2, 0, 1);
    rst = 1'b1;
    #1;
    check_eq("abort_pkt_rdy_in_rst", pkt_rdy, 0);
    check_eq("abort_enq_val_in_rst", enqueue_pkt_req_val, 0);
    tick();
    rst = 1'b0;
    exp_enq  = 0;
    exp_drop = 0;
    q_full_resp_val = 1'b1;
    #1;
    check_eq("abort_vals", {q_full_req_val, enqueue_pkt_req_val, pkt_result_val}, 0);
    check_eq("abort_pkt_rdy", pkt_rdy, 1);
    check_eq("abort_enq_cnt", enq_cnt, 0);
    check_eq("abort_drop_cnt", drop_cnt, 0);
    check_eq("abort_stray_resp_rdy", q_full_resp_rdy, 0);
    tick();
    q_full_resp_val = 1'b0;
    check_eq("abort_still_idle", pkt_rdy, 1);
    check_eq("abort_no_result", pkt_result_val, 0);
    run_pkt(8'h44, 64'h0000_0000_FFFF_FFFF, 7, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
